cdc_fifo_gray_src_multi: RTL and testbench

// - Source-clock half of NumChan independent gray-pointer CDC FIFOs. Generalises the per-channel

---
 rtl/cdc_pkg.sv | 34 +++
 rtl/cdc_fifo_gray_src_chan.sv | 143 ++++++++++++++
 rtl/cdc_fifo_gray_src_multi.sv | 52 +++++
 tb/tb_cdc_fifo_gray_src_multi.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared helpers for the gray-pointer CDC FIFO source halves.
package cdc_pkg;

  // Gray conversions run on a fixed wide word; callers zero-extend their
  // pointer in and truncate the result back to pointer width.
  localparam int unsigned GrayMaxW = 32;
  typedef logic [GrayMaxW-1:0] gray_word_t;

  // Occupancy of the optional input skid buffer.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

  // Pointer width: one extra bit beyond the index distinguishes full from empty.
  function automatic int unsigned ptr_width(input int unsigned log_depth);
    return log_depth + 1;
  endfunction

  function automatic gray_word_t bin2gray(input gray_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic gray_word_t gray2bin(input gray_word_t gray);
    gray_word_t bin;
    bin = gray;
    for (int i = 1; i < int'(GrayMaxW); i++) begin
      bin = bin ^ (gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/cdc_fifo_gray_src_chan.sv
// One source-side channel: storage, gray write pointer, read-pointer
// synchroniser, full/fill, and an optional registered-ready skid buffer.
//
// Skid buffer states (RegIn != 0):
//   state      | meaning
//   SKID_EMPTY | nothing buffered, ready high
//   SKID_ONE   | head holds a beat waiting for the FIFO, ready high
//   SKID_TWO   | head and tail hold beats, ready low
module cdc_fifo_gray_src_chan
  import cdc_pkg::*;
#(
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned LogDepth   = 1,
  parameter int unsigned SyncStages = 2,
  parameter int unsigned RegIn      = 0
) (
  input  logic                                src_clk_i,
  input  logic                                src_rst_i,
  input  logic [DataWidth-1:0]                src_data_i,
  input  logic                                src_valid_i,
  output logic                                src_ready_o,
  output logic [LogDepth:0]                   src_fill_o,
  output logic                                src_idle_o,
  output logic [(2**LogDepth)*DataWidth-1:0]  async_data_o,
  output logic [LogDepth:0]                   async_wptr_o,
  input  logic [LogDepth:0]                   async_rptr_i
);

  localparam int unsigned PtrW  = ptr_width(LogDepth);
  localparam int unsigned Depth = 2**LogDepth;
  typedef logic [PtrW-1:0] ptr_t;

  logic [Depth-1:0][DataWidth-1:0] mem_q;
  ptr_t [SyncStages-1:0]           rptr_sync_q;
  ptr_t                            wptr_bin_q;
  ptr_t                            wptr_bin_next;
  ptr_t                            wptr_gray_q;
  ptr_t                            rptr_s;
  ptr_t                            rptr_bin;
  logic                            full;
  logic                            wr_valid;
  logic                            wr_ready;
  logic                            wr_fire;
  logic [DataWidth-1:0]            wr_data;
  logic                            spill_empty;

  assign rptr_s        = rptr_sync_q[SyncStages-1];
  assign rptr_bin      = PtrW'(gray2bin(gray_word_t'(rptr_s)));
  assign full          = (wptr_bin_q ^ rptr_bin) == {1'b1, {LogDepth{1'b0}}};
  assign src_fill_o    = wptr_bin_q - rptr_bin;
  assign wr_ready      = !full;
  assign wr_fire       = wr_valid && wr_ready;
  assign wptr_bin_next = wptr_bin_q + ptr_t'(1);
  assign async_data_o  = mem_q;
  assign async_wptr_o  = wptr_gray_q;
  assign src_idle_o    = (src_fill_o == '0) && spill_empty;

  // Bring the destination's gray read pointer into the source clock.
  always_ff @(posedge src_clk_i or posedge src_rst_i) begin
    if (src_rst_i) begin
      rptr_sync_q <= '0;
    end else begin
      rptr_sync_q[0] <= async_rptr_i;
      for (int i = 1; i < int'(SyncStages); i++) begin
        rptr_sync_q[i] <= rptr_sync_q[i-1];
      end
    end
  end

  // Write storage and advance binary and gray pointers on the same edge so the
  // exported gray pointer comes straight from a flop.
  always_ff @(posedge src_clk_i or posedge src_rst_i) begin
    if (src_rst_i) begin
      mem_q       <= '0;
      wptr_bin_q  <= '0;
      wptr_gray_q <= '0;
    end else if (wr_fire) begin
      mem_q[wptr_bin_q[LogDepth-1:0]] <= wr_data;
      wptr_bin_q                      <= wptr_bin_next;
      wptr_gray_q                     <= PtrW'(bin2gray(gray_word_t'(wptr_bin_next)));
    end
  end

  if (RegIn != 0) begin : g_spill
    skid_state_e          state_q;
    logic [DataWidth-1:0] head_q;
    logic [DataWidth-1:0] tail_q;
    logic                 ready_q;

    assign wr_valid    = (state_q != SKID_EMPTY);
    assign wr_data     = head_q;
    assign src_ready_o = ready_q;
    assign spill_empty = (state_q == SKID_EMPTY);

    // Skid FSM; ready is registered so the source never sees the rptr path.
    always_ff @(posedge src_clk_i or posedge src_rst_i) begin
      if (src_rst_i) begin
        state_q <= SKID_EMPTY;
        head_q  <= '0;
        tail_q  <= '0;
        ready_q <= 1'b1;
      end else begin
        case (state_q)
          SKID_EMPTY: begin
            if (src_valid_i) begin
              head_q  <= src_data_i;
              state_q <= SKID_ONE;
            end
            ready_q <= 1'b1;
          end
          SKID_ONE: begin
            if (wr_ready && src_valid_i) begin
              head_q <= src_data_i;
            end else if (wr_ready) begin
              state_q <= SKID_EMPTY;
            end else if (src_valid_i) begin
              tail_q  <= src_data_i;
              state_q <= SKID_TWO;
              ready_q <= 1'b0;
            end
          end
          SKID_TWO: begin
            if (wr_ready) begin
              head_q  <= tail_q;
              state_q <= SKID_ONE;
              ready_q <= 1'b1;
            end
          end
          default: begin
            state_q <= SKID_EMPTY;
            ready_q <= 1'b1;
          end
        endcase
      end
    end
  end else begin : g_direct
    assign wr_valid    = src_valid_i;
    assign wr_data     = src_data_i;
    assign src_ready_o = wr_ready;
    assign spill_empty = 1'b1;
  end

endmodule

// File: rtl/cdc_fifo_gray_src_multi.sv
// Source-clock halves of NumChan independent gray-pointer CDC FIFOs.
// Timing: async_data_o, async_wptr_o and async_rptr_i are max-delay/skew
// paths; the first rptr synchroniser flop of each channel is a false path.
module cdc_fifo_gray_src_multi
  import cdc_pkg::*;
#(
  parameter int unsigned NumChan    = 5,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned LogDepth   = 1,
  parameter int unsigned SyncStages = 2,
  parameter int unsigned RegIn      = 0
) (
  input  logic                                        src_clk_i,
  input  logic                                        src_rst_i,
  input  logic [NumChan*DataWidth-1:0]                src_data_i,
  input  logic [NumChan-1:0]                          src_valid_i,
  output logic [NumChan-1:0]                          src_ready_o,
  output logic [NumChan*(LogDepth+1)-1:0]             src_fill_o,
  output logic                                        src_idle_o,
  output logic [NumChan*(2**LogDepth)*DataWidth-1:0]  async_data_o,
  output logic [NumChan*(LogDepth+1)-1:0]             async_wptr_o,
  input  logic [NumChan*(LogDepth+1)-1:0]             async_rptr_i
);

  localparam int unsigned PtrW  = ptr_width(LogDepth);
  localparam int unsigned MemW  = (2**LogDepth) * DataWidth;

  logic [NumChan-1:0] chan_idle;

  for (genvar c = 0; c < NumChan; c++) begin : g_chan
    cdc_fifo_gray_src_chan #(
      .DataWidth  (DataWidth),
      .LogDepth   (LogDepth),
      .SyncStages (SyncStages),
      .RegIn      (RegIn)
    ) u_chan (
      .src_clk_i    (src_clk_i),
      .src_rst_i    (src_rst_i),
      .src_data_i   (src_data_i[c*DataWidth +: DataWidth]),
      .src_valid_i  (src_valid_i[c]),
      .src_ready_o  (src_ready_o[c]),
      .src_fill_o   (src_fill_o[c*PtrW +: PtrW]),
      .src_idle_o   (chan_idle[c]),
      .async_data_o (async_data_o[c*MemW +: MemW]),
      .async_wptr_o (async_wptr_o[c*PtrW +: PtrW]),
      .async_rptr_i (async_rptr_i[c*PtrW +: PtrW])
    );
  end

  assign src_idle_o = &chan_idle;

endmodule

// File: tb/tb_cdc_fifo_gray_src_multi.sv
// Directed bench: two-channel, depth-2 instances, one direct and one with
// the input skid buffer, sharing clock and reset.
module tb_cdc_fifo_gray_src_multi;

  logic        clk;
  logic        clk_en;
  logic        rst;

  logic [15:0] d_data;
  logic [1:0]  d_valid;
  logic [1:0]  d_ready;
  logic [3:0]  d_fill;
  logic        d_idle;
  logic [31:0] d_adata;
  logic [3:0]  d_wptr;
  logic [3:0]  d_rptr;

  logic [15:0] r_data;
  logic [1:0]  r_valid;
  logic [1:0]  r_ready;
  logic [3:0]  r_fill;
  logic        r_idle;
  logic [31:0] r_adata;
  logic [3:0]  r_wptr;
  logic [3:0]  r_rptr;

  int n_vec;
  int n_miss;

  cdc_fifo_gray_src_multi #(
    .NumChan(2), .DataWidth(8), .LogDepth(1), .SyncStages(2), .RegIn(0)
  ) u_direct (
    .src_clk_i    (clk),
    .src_rst_i    (rst),
    .src_data_i   (d_data),
    .src_valid_i  (d_valid),
    .src_ready_o  (d_ready),
    .src_fill_o   (d_fill),
    .src_idle_o   (d_idle),
    .async_data_o (d_adata),
    .async_wptr_o (d_wptr),
    .async_rptr_i (d_rptr)
  );

  cdc_fifo_gray_src_multi #(
    .NumChan(2), .DataWidth(8), .LogDepth(1), .SyncStages(2), .RegIn(1)
  ) u_reg (
    .src_clk_i    (clk),
    .src_rst_i    (rst),
    .src_data_i   (r_data),
    .src_valid_i  (r_valid),
    .src_ready_o  (r_ready),
    .src_fill_o   (r_fill),
    .src_idle_o   (r_idle),
    .async_data_o (r_adata),
    .async_wptr_o (r_wptr),
    .async_rptr_i (r_rptr)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    d_valid = '0; d_data = '0; d_rptr = '0;
    r_valid = '0; r_data = '0; r_rptr = '0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  function automatic logic [1:0] b2g(input logic [1:0] b);
    return {b[1], b[1] ^ b[0]};
  endfunction

  logic [1:0] exp_w, m1, m2, drv, efill, wr_idx;
  logic       erdy, accepted;
  logic [7:0] exp_d;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0; n_miss = 0;
    clk = 1'b0; clk_en = 1'b0; rst = 1'b0;
    d_valid = '0; d_data = '0; d_rptr = '0;
    r_valid = '0; r_data = '0; r_rptr = '0;

    // Reset with no clock running
    #1 rst = 1'b1;
    #2;
    check_val("rst_ready",  d_ready, 2'b11);
    check_val("rst_fill",   d_fill,  4'h0);
    check_val("rst_idle",   d_idle,  1'b1);
    check_val("rst_wptr",   d_wptr,  4'h0);
    check_val("rst_data",   d_adata, 32'h0);
    check_val("rst_r_ready", r_ready, 2'b11);
    check_val("rst_r_idle",  r_idle,  1'b1);
    #1 rst = 1'b0;
    clk_en = 1'b1;
    tick;

    // Fill channel 0 with rptr held at 0
    d_valid[0] = 1'b1; d_data[7:0] = 8'hA1;
    tick;
    check_val("fill_wptr1", d_wptr[1:0], 2'b01);
    check_val("fill_mem0",  d_adata[7:0], 8'hA1);
    check_val("fill_rdy1",  d_ready[0], 1'b1);
    check_val("fill_fill1", d_fill[1:0], 2'd1);
    d_data[7:0] = 8'hB2;
    tick;
    check_val("fill_wptr2", d_wptr[1:0], 2'b11);
    check_val("fill_mem1",  d_adata[15:8], 8'hB2);
    check_val("fill_rdy2",  d_ready[0], 1'b0);
    check_val("fill_fill2", d_fill[1:0], 2'd2);
    check_val("fill_idle",  d_idle, 1'b0);
    d_data[7:0] = 8'hC3;
    tick;
    check_val("hold_wptr", d_wptr[1:0], 2'b11);
    check_val("hold_mem0", d_adata[7:0], 8'hA1);
    check_val("hold_fill", d_fill[1:0], 2'd2);

    // Drain one entry: rptr gray 01 reaches full/fill after two edges
    d_rptr[1:0] = 2'b01;
    tick;
    check_val("drain_rdy_e1",  d_ready[0], 1'b0);
    check_val("drain_fill_e1", d_fill[1:0], 2'd2);
    tick;
    check_val("drain_rdy_e2",  d_ready[0], 1'b1);
    check_val("drain_fill_e2", d_fill[1:0], 2'd1);
    tick;
    check_val("drain_mem0", d_adata[7:0], 8'hC3);
    check_val("drain_wptr", d_wptr[1:0], 2'b10);
    check_val("drain_fill", d_fill[1:0], 2'd2);
    d_valid[0] = 1'b0;

    // Wrap: destination reads each entry as soon as it is written
    do_reset;
    exp_w = '0; m1 = '0; m2 = '0; drv = '0;
    for (int k = 0; k < 10; k++) begin
      exp_d = 8'(8'h10 + k);
      d_valid[0] = 1'b1; d_data[7:0] = exp_d;
      accepted = 1'b0;
      for (int t = 0; t < 8 && !accepted; t++) begin
        efill = exp_w - m2;
        erdy  = (efill != 2'd2);
        check_val("wrap_fill",  d_fill[1:0], efill);
        check_val("wrap_ready", d_ready[0], erdy);
        wr_idx = exp_w;
        tick;
        m2 = m1;
        m1 = drv;
        if (erdy) begin
          exp_w = exp_w + 2'd1;
          accepted = 1'b1;
          check_val("wrap_data", d_adata[wr_idx[0]*8 +: 8], exp_d);
        end
        check_val("wrap_wptr", d_wptr[1:0], b2g(exp_w));
        drv = exp_w;
        d_rptr[1:0] = b2g(drv);
      end
      check_val("wrap_accept", accepted, 1'b1);
    end
    d_valid[0] = 1'b0;

    // Independence: ch1 full with frozen rptr, ch0 still streams
    do_reset;
    d_valid = 2'b10; d_data[15:8] = 8'h51;
    tick;
    d_data[15:8] = 8'h52;
    tick;
    check_val("ind_ch1_rdy",  d_ready[1], 1'b0);
    check_val("ind_ch1_fill", d_fill[3:2], 2'd2);
    d_data[15:8] = 8'h53;
    d_valid[0] = 1'b1; d_data[7:0] = 8'h01;
    tick;
    check_val("ind_ch0_wptr1", d_wptr[1:0], 2'b01);
    check_val("ind_ch1_wptr",  d_wptr[3:2], 2'b11);
    check_val("ind_ch1_mem0",  d_adata[23:16], 8'h51);
    d_data[7:0] = 8'h02;
    tick;
    check_val("ind_ch0_wptr2", d_wptr[1:0], 2'b11);
    check_val("ind_ch0_mem1",  d_adata[15:8], 8'h02);
    check_val("ind_ch1_mem1",  d_adata[31:24], 8'h52);
    check_val("ind_idle_busy", d_idle, 1'b0);
    d_valid = 2'b00;
    d_rptr[1:0] = 2'b11;
    tick;
    tick;
    check_val("ind_ch0_empty", d_fill[1:0], 2'd0);
    check_val("ind_ch1_still", d_fill[3:2], 2'd2);
    check_val("ind_idle_ch1",  d_idle, 1'b0);
    d_rptr[3:2] = 2'b11;
    tick;
    check_val("ind_idle_e1", d_idle, 1'b0);
    tick;
    check_val("ind_idle_e2", d_idle, 1'b1);
    check_val("ind_ready",   d_ready, 2'b11);

    // Skid-buffered instance: back-to-back stream, then reset mid-burst
    do_reset;
    r_valid[0] = 1'b1; r_data[7:0] = 8'hA0;
    tick;
    check_val("reg_wptr_e1", r_wptr[1:0], 2'b00);
    check_val("reg_rdy_e1",  r_ready[0], 1'b1);
    check_val("reg_idle_e1", r_idle, 1'b0);
    check_val("reg_fill_e1", r_fill[1:0], 2'd0);
    r_data[7:0] = 8'hA1;
    tick;
    check_val("reg_wptr_e2", r_wptr[1:0], 2'b01);
    check_val("reg_mem0",    r_adata[7:0], 8'hA0);
    check_val("reg_rdy_e2",  r_ready[0], 1'b1);
    r_data[7:0] = 8'hA2;
    tick;
    check_val("reg_wptr_e3", r_wptr[1:0], 2'b11);
    check_val("reg_mem1",    r_adata[15:8], 8'hA1);
    check_val("reg_fill_e3", r_fill[1:0], 2'd2);
    check_val("reg_rdy_e3",  r_ready[0], 1'b1);
    r_data[7:0] = 8'hA3;
    tick;
    check_val("reg_wptr_e4", r_wptr[1:0], 2'b11);
    check_val("reg_rdy_e4",  r_ready[0], 1'b0);
    check_val("reg_rdy_ch1", r_ready[1], 1'b1);
    rst = 1'b1;
    #1;
    check_val("reg_rst_wptr", r_wptr, 4'h0);
    check_val("reg_rst_data", r_adata, 32'h0);
    check_val("reg_rst_fill", r_fill, 4'h0);
    check_val("reg_rst_idle", r_idle, 1'b1);
    rst = 1'b0;
    r_valid = 2'b00;
    tick;
    check_val("reg_post_rdy",  r_ready, 2'b11);
    check_val("reg_post_idle", r_idle, 1'b1);
    check_val("reg_post_wptr", r_wptr, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
